tmds_channel_encoder: RTL
=========================

// Module: tmds_channel_encoder
// PURPOSE
//  Full DVI 1.0 TMDS 8b/10b encoder for one colour channel, with running-disparity DC balance.
//  Sits between the video timing/pixel generator and the x5 DDR serializer; three instances (R, G, B) form a full link.
//  Replaces the fixed 5-ones symbol subset, so arbitrary 8-bit colour can be sent.
//  Output symbol is LSB-first: symbol[0] goes on the wire first, matching the serializer shift direction.
// PARAMETERS
//  RESET_SYMBOL  10'b1101010100  symbol driven during and after reset until pipeline refills (CTL 00)
// PORTS
//  clk        in   1   pixel clock (25 MHz for 640x480); all logic on rising edge
//  rst        in   1   asynchronous, active-high reset
//  de         in   1   data enable: 1 = active video (encode data), 0 = blanking (send ctrl)
//  data       in   8   pixel component, valid when de=1
//  ctrl       in   2   {c1,c0} control bits, valid when de=0; ch0 carries {vsync,hsync}
//  symbol     out  10  encoded TMDS symbol, registered
//  de_out     out  1   de delayed to align with symbol (debug/alignment of sibling stages)
// BEHAVIOUR
//  Reset (async assert, sync release): symbol=RESET_SYMBOL, de_out=0, disparity cnt=0, all pipe regs 0/ctrl 00.
//  Latency: exactly 2 clk; inputs at edge N appear on symbol after edge N+2. One symbol per clk, no stalls.
//  Stage 1 (register): n1d = ones(data); xnor_sel = (n1d>4) | (n1d==4 & data[0]==0);
//   q_m[0]=data[0]; q_m[i]= xnor_sel ? ~(q_m[i-1]^data[i]) : (q_m[i-1]^data[i]), i=1..7; q_m[8]=~xnor_sel.
//   Register q_m[8:0], n1q=ones(q_m[7:0]) (4b), de, ctrl.
//  Stage 2 (register), n0q = 8-n1q, cnt is 5-bit two's complement:
//   de=0: symbol = CTL(ctrl): 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011; cnt<=0.
//   de=1, cnt==0 or n1q==4: symbol={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]};
//     cnt <= q_m[8] ? cnt+n1q-n0q : cnt+n0q-n1q.
//   de=1, (cnt>0 & n1q>4) | (cnt<0 & n1q<4): symbol={1, q_m[8], ~q_m[7:0]}; cnt <= cnt + 2*q_m[8] + n0q - n1q.
//   de=1, otherwise: symbol={0, q_m[8], q_m[7:0]}; cnt <= cnt - 2*~q_m[8] + n1q - n0q.
//  Arithmetic: all cnt math sign-extended to 5 bits; |cnt| never exceeds 10, so no saturation logic; 
//   overflow is a design error (assert in bench).
//  de transitions: first active pixel after blanking always starts from cnt=0; 
//   a 1-cycle de pulse is encoded normally.
//  Reset mid-frame: pipeline flushed, cnt cleared; first two post-reset symbols are RESET_SYMBOL.
// STRUCTURE
//  Shared package tmds_pkg: CTL_00..CTL_11 symbol constants, function ones8 (popcount of 8 bits).
//  One natural sub-module: tmds_qm_stage (stage 1, combinational q_m + register); 
//   stage 2/disparity stays in this module.
// TESTING
//  Reset: assert rst async mid-cycle -> symbol=10'h354 immediately, de_out=0; held 2 clk after release.
//  Ctrl: de=0, ctrl=00/01/10/11 -> after 2 clk symbol=10'h354/10'h0AB/10'h154/10'h2AB; cnt=0.
//  Disparity: from cnt=0, de=1 data=8'h00 twice -> symbols 10'h100 (cnt=-8) then 10'h3FF (cnt=+2).
//  XNOR path: from cnt=0, data=8'hFF -> symbol 10'h200, cnt=-8.
//  DC balance: 10k random data bytes, de=1 -> every symbol decodes back to its data, |cnt|<=10 throughout,
//   cumulative (ones-zeros) over stream bounded by +/-10.
//  Blanking/active mix: 640 active + 160 blank per line, 3 lines -> cnt=0 on each first active pixel;
//   de_out equals de delayed 2.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period symbols, the stage-1 payload and popcount helpers.
package tmds_pkg;

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    // Running disparity stays within +/-10, so 5-bit two's complement is enough.
    localparam int DISP_W = 5;
    typedef logic signed [DISP_W-1:0] disp_t;

    typedef struct packed {
        logic [8:0] q_m;
        logic [3:0] n1q;
        logic       de;
        logic [1:0] ctrl;
        logic       vld;
    } qm_stage_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTL_00;
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            default: s = CTL_11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS encoder: transition-minimising q_m word plus its ones count, registered.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    output qm_stage_t  o_stage
);

    logic [8:0] w_q_m;
    logic [3:0] w_n1q;
    qm_stage_t  r_stage_p1;

    // XNOR chaining is chosen when it yields fewer transitions; q_m[8] records the choice.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1d;
        logic       xnor_sel;
        logic [8:0] q;
        n1d      = ones8(d);
        xnor_sel = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xnor_sel;
        return q;
    endfunction

    assign w_q_m = qm_encode(i_data);
    assign w_n1q = ones8(w_q_m[7:0]);

    // ---- stage 1 register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_p1 <= '0;
        end else begin
            r_stage_p1.q_m  <= w_q_m;
            r_stage_p1.n1q  <= w_n1q;
            r_stage_p1.de   <= i_de;
            r_stage_p1.ctrl <= i_ctrl;
            r_stage_p1.vld  <= 1'b1;
        end
    end

    assign o_stage = r_stage_p1;

endmodule

// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel with running-disparity DC balance.
// Two-clock latency: q_m generation, then symbol selection and disparity update.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter logic [9:0] RESET_SYMBOL = CTL_00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    output logic [9:0] symbol,
    output logic       de_out
);

    localparam disp_t ZERO  = 5'sd0;
    localparam disp_t TWO   = 5'sd2;
    localparam disp_t EIGHT = 5'sd8;

    qm_stage_t  w_stage_p1;
    disp_t      r_cnt;
    disp_t      w_cnt_next;
    disp_t      w_n1q;
    disp_t      w_n0q;
    logic [9:0] r_symbol_p2;
    logic [9:0] w_symbol_next;
    logic       r_de_p2;
    logic       w_q8;
    logic [7:0] w_qm;

    tmds_qm_stage u_qm_stage (
        .clk     (clk),
        .rst     (rst),
        .i_de    (de),
        .i_data  (data),
        .i_ctrl  (ctrl),
        .o_stage (w_stage_p1)
    );

    function automatic disp_t disp_step(input disp_t cnt, input disp_t bias,
                                        input disp_t plus, input disp_t minus);
        return cnt + bias + plus - minus;
    endfunction

    always_comb begin
        w_n1q         = disp_t'({1'b0, w_stage_p1.n1q});
        w_n0q         = EIGHT - w_n1q;
        w_q8          = w_stage_p1.q_m[8];
        w_qm          = w_stage_p1.q_m[7:0];
        w_symbol_next = RESET_SYMBOL;
        w_cnt_next    = ZERO;
        if (!w_stage_p1.vld) begin
            w_symbol_next = RESET_SYMBOL;
            w_cnt_next    = ZERO;
        end else if (!w_stage_p1.de) begin
            w_symbol_next = ctl_symbol(w_stage_p1.ctrl);
            w_cnt_next    = ZERO;
        end else if ((r_cnt == ZERO) || (w_stage_p1.n1q == 4'd4)) begin
            w_symbol_next = {~w_q8, w_q8, (w_q8 ? w_qm : ~w_qm)};
            w_cnt_next    = w_q8 ? disp_step(r_cnt, ZERO, w_n1q, w_n0q)
                                 : disp_step(r_cnt, ZERO, w_n0q, w_n1q);
        end else if (((r_cnt > ZERO) && (w_stage_p1.n1q > 4'd4)) ||
                     ((r_cnt < ZERO) && (w_stage_p1.n1q < 4'd4))) begin
            // Inverting pulls the running disparity back toward zero.
            w_symbol_next = {1'b1, w_q8, ~w_qm};
            w_cnt_next    = disp_step(r_cnt, (w_q8 ? TWO : ZERO), w_n0q, w_n1q);
        end else begin
            w_symbol_next = {1'b0, w_q8, w_qm};
            w_cnt_next    = disp_step(r_cnt, (w_q8 ? ZERO : -TWO), w_n1q, w_n0q);
        end
    end

    // ---- stage 2 register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_symbol_p2 <= RESET_SYMBOL;
            r_cnt       <= ZERO;
            r_de_p2     <= 1'b0;
        end else begin
            r_symbol_p2 <= w_symbol_next;
            r_cnt       <= w_cnt_next;
            r_de_p2     <= w_stage_p1.vld & w_stage_p1.de;
        end
    end

    assign symbol = r_symbol_p2;
    assign de_out = r_de_p2;

endmodule
